// File: rtl/pio_mult_pkg.sv
// Shared types and sizing for the PIO shift-add multiplier.
package pio_mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned PROD_W        = 2 * DEFAULT_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Product width for a given operand width.
  function automatic int unsigned prod_w(input int unsigned w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level control bit; the history register resets
// high so a level already asserted at reset release is not seen as an edge.
module rise_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise_c
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (reset) sig_q <= RESET_VAL;
    else       sig_q <= sig;
  end

  assign rise_c = sig & ~sig_q;

endmodule

// File: rtl/pio_shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier with fixed WIDTH-cycle latency;
// product is written once at completion so software never sees a partial sum.
module pio_shift_add_multiplier
  import pio_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            op_a,
  input  logic [WIDTH-1:0]            op_b,
  input  logic                        start,
  output logic [prod_w(WIDTH)-1:0]    product,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned PW    = prod_w(WIDTH);
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [PW-1:0]     acc_sum_c;
  logic              start_rise_c;

  rise_detect #(.RESET_VAL(1'b1)) u_start_rise (
    .clk    (clk),
    .reset  (reset),
    .sig    (start),
    .rise_c (start_rise_c)
  );

  // Partial product for the current multiplier bit.
  assign acc_sum_c = acc + (b_sh[0] ? a_sh : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_rise_c) begin
            a_sh  <= PW'(op_a);
            b_sh  <= op_b;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          // Start edges here are dropped, including on the final cycle.
          acc  <= acc_sum_c;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            product <= acc_sum_c;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_shift_add_multiplier.sv
// Self-checking bench: randomized and directed operations against a plain
// arithmetic reference, with latency, busy/done and hold behaviour checks.
module tb_pio_shift_add_multiplier;

  localparam int unsigned W   = 16;
  localparam int unsigned LAT = 17;  // negedges from start raise to done

  logic          clk;
  logic          reset;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          start;
  logic [2*W-1:0] product;
  logic          busy;
  logic          done;

  int checks;
  int passed;

  pio_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .op_a    (op_a),
    .op_b    (op_b),
    .start   (start),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_mult(input logic [15:0] a, input logic [15:0] b);
    return 32'(a) * 32'(b);
  endfunction

  // Lower start for one cycle, then raise it with new operands (at a negedge).
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b0;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
  endtask

  // Wait (bounded) for done, observing busy and product hold along the way.
  task automatic wait_done(input logic [31:0] prev, output int cyc,
                           output bit busy_ok, output bit stable_ok);
    cyc = 0; busy_ok = 1'b1; stable_ok = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (!done) begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (product !== prev) stable_ok = 1'b0;
      end
    end while (!done && cyc < 40);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({product, busy, done} !== 34'h0)
      $display("FAIL reset_state product=%h busy=%b done=%b want 0/0/0", product, busy, done);
    else passed++;
  endtask

  task automatic run_and_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [31:0] prev, exp;
    int cyc; bit bok, sok;
    prev = product;
    exp  = model_mult(a, b);
    launch(a, b);
    wait_done(prev, cyc, bok, sok);
    checks++;
    if (cyc !== LAT) $display("FAIL %s_latency got=%0d want=%0d", name, cyc, LAT);
    else passed++;
    checks++;
    if (product !== exp) $display("FAIL %s_product got=%h want=%h", name, product, exp);
    else passed++;
    checks++;
    if ({busy, done} !== 2'b01) $display("FAIL %s_flags busy=%b done=%b want 0/1", name, busy, done);
    else passed++;
    checks++;
    if (!(bok && sok)) $display("FAIL %s_run busy_held=%b product_held=%b want 1/1", name, bok, sok);
    else passed++;
  endtask

  task automatic test_basic();
    run_and_check("basic_3x5", 16'd3, 16'd5);
  endtask

  task automatic test_max_operands();
    run_and_check("max", 16'hFFFF, 16'hFFFF);
    checks++;
    if (product !== 32'hFFFE0001) $display("FAIL max_const got=%h want=fffe0001", product);
    else passed++;
    run_and_check("zero_b", 16'h1234, 16'h0000);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_and_check("random", 16'($urandom), 16'($urandom));
  endtask

  task automatic test_busy_interaction();
    logic [31:0] prev, exp;
    logic [W-1:0] a, b;
    int bad, busy_seen;
    a = 16'($urandom_range(1, 16'hFFFF));
    b = 16'($urandom_range(1, 16'hFFFF));
    exp = model_mult(a, b);
    prev = product;
    bad = 0;
    launch(a, b);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0 || product !== prev) bad++;
      if (j == 3) start = 1'b0;
      if (j == 4) begin start = 1'b1; op_a = 16'd7; op_b = 16'($urandom); end
      if (j == 15) start = 1'b0;
      if (j == 16) start = 1'b1;  // rise lands on the completion edge
    end
    checks++;
    if (bad != 0) $display("FAIL busy_hold bad_cycles=%0d want=0", bad);
    else passed++;
    @(negedge clk);
    checks++;
    if (product !== exp || done !== 1'b1 || busy !== 1'b0)
      $display("FAIL busy_result product=%h done=%b busy=%b want %h/1/0", product, done, busy, exp);
    else passed++;
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b1 || product !== exp) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) $display("FAIL busy_no_requeue bad_cycles=%0d want=0", busy_seen);
    else passed++;
  endtask

  task automatic test_held_start();
    int bad;
    start = 1'b1; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL held_start_no_op bad_cycles=%0d want=0", bad);
    else passed++;
    run_and_check("held_then_toggle", 16'd11, 16'd13);
  endtask

  task automatic test_reset_mid();
    launch(16'($urandom), 16'($urandom));
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({product, busy, done} !== 34'h0)
      $display("FAIL reset_mid product=%h busy=%b done=%b want 0/0/0", product, busy, done);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    run_and_check("after_reset_mid", 16'd321, 16'd123);
  endtask

  task automatic test_back_to_back();
    run_and_check("b2b_first", 16'd7, 16'd9);
    checks++;
    if (product !== 32'h3F) $display("FAIL b2b_first_const got=%h want=3f", product);
    else passed++;
    launch(16'd100, 16'd200);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || product !== 32'h3F)
      $display("FAIL b2b_load done=%b busy=%b product=%h want 0/1/3f", done, busy, product);
    else passed++;
    repeat (15) @(negedge clk);
    checks++;
    if (done !== 1'b0) $display("FAIL b2b_not_early done=%b want 0", done);
    else passed++;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || product !== 32'h4E20)
      $display("FAIL b2b_second done=%b product=%h want 1/4e20", done, product);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_basic();
    test_max_operands();
    test_random();
    test_busy_interaction();
    test_held_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
